// File: rtl/i2c_write_seq_ctrl_if.sv
// Request/status and I2C pin bundle for the single-register I2C write sequencer.
// slave modport: the sequencer itself. master modport: the requester plus bus environment.
interface i2c_write_seq_ctrl_if;
    logic       req_i;
    logic [6:0] dev_addr_i;
    logic [7:0] reg_addr_i;
    logic [7:0] data_i;
    logic       busy_o;
    logic       done_o;
    logic       ack_err_o;
    logic       scl_o;
    logic       sda_oe_o;
    logic       sda_i;

    modport slave (
        input  req_i, dev_addr_i, reg_addr_i, data_i, sda_i,
        output busy_o, done_o, ack_err_o, scl_o, sda_oe_o
    );

    modport master (
        output req_i, dev_addr_i, reg_addr_i, data_i, sda_i,
        input  busy_o, done_o, ack_err_o, scl_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_write_seq_ctrl.sv
// I2C single-register write sequencer: START, {dev,W}, reg, data, STOP.
// Each SCL bit is split into four quarter periods of CLK_DIV clocks.
// Optional feature macro: I2C_WRITE_SEQ_RETRY_EN -- a NACKed transaction is
// repeated once from START (after its STOP) before reporting the result.
module i2c_write_seq_ctrl #(
    parameter int CLK_DIV = 62,
    parameter int DIV_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    i2c_write_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic              nack_q, nack_d;
    logic [6:0]        dev_q, dev_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        dat_q, dat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              scl_q, scl_d;
    logic              sda_oe_q, sda_oe_d;
`ifdef I2C_WRITE_SEQ_RETRY_EN
    logic              retried_q, retried_d;
`endif

    logic              active_s;
    logic              tick_s;
    logic [7:0]        next_byte_s;
    logic              next_bit_s;

    // Pin levels {scl, sda_oe} for a given state/quarter; bit_v is the data bit in BYTE.
    function automatic logic [1:0] bus_level(input state_e st, input logic [1:0] q, input logic bit_v);
        logic [1:0] lvl;
        case (st)
            ST_START: begin
                case (q)
                    2'd0:    lvl = 2'b10;
                    2'd1:    lvl = 2'b11;
                    default: lvl = 2'b01;
                endcase
            end
            ST_BYTE: lvl = {((q == 2'd1) || (q == 2'd2)), ~bit_v};
            ST_ACK:  lvl = {((q == 2'd1) || (q == 2'd2)), 1'b0};
            ST_STOP: begin
                case (q)
                    2'd0:    lvl = 2'b01;
                    2'd1:    lvl = 2'b11;
                    default: lvl = 2'b10;
                endcase
            end
            default: lvl = 2'b10;
        endcase
        return lvl;
    endfunction

    assign active_s = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign tick_s   = active_s && (cnt_q == DIV_LAST);

    // Next-state, quarter/bit/byte sequencing and registered pin levels.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        nack_d    = nack_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        dat_d     = dat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
`ifdef I2C_WRITE_SEQ_RETRY_EN
        retried_d = retried_q;
`endif

        if (active_s && !tick_s) begin
            cnt_d = cnt_q + DIV_W'(1);
        end else begin
            cnt_d = {DIV_W{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    dev_d     = bus.dev_addr_i;
                    reg_d     = bus.reg_addr_i;
                    dat_d     = bus.data_i;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                    qtr_d     = 2'd0;
                    byte_d    = 2'd0;
                    bit_d     = 3'd7;
                    nack_d    = 1'b0;
`ifdef I2C_WRITE_SEQ_RETRY_EN
                    retried_d = 1'b0;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (qtr_q == 2'd3) begin
                        state_d = ST_BYTE;
                        qtr_d   = 2'd0;
                        bit_d   = 3'd7;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    qtr_d = qtr_q;
                end
            end
            ST_BYTE: begin
                if (tick_s) begin
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        if (bit_q == 3'd0) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    qtr_d = qtr_q;
                end
            end
            ST_ACK: begin
                if (tick_s) begin
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        if (nack_q || (byte_q == 2'd2)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_BYTE;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                        end
                    end else begin
                        // Slave response is taken at the end of the second SCL-high quarter.
                        if (qtr_q == 2'd2) begin
                            nack_d = bus.sda_i;
                        end else begin
                            nack_d = nack_q;
                        end
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    qtr_d = qtr_q;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (qtr_q == 2'd3) begin
`ifdef I2C_WRITE_SEQ_RETRY_EN
                        if (nack_q && !retried_q) begin
                            state_d   = ST_START;
                            qtr_d     = 2'd0;
                            byte_d    = 2'd0;
                            bit_d     = 3'd7;
                            nack_d    = 1'b0;
                            retried_d = 1'b1;
                        end else begin
                            state_d   = ST_DONE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            ack_err_d = nack_q;
                        end
`else
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        ack_err_d = nack_q;
`endif
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    qtr_d = qtr_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Pins are derived from the next state so they line up with the registered state.
        case (byte_d)
            2'd0:    next_byte_s = {dev_d, 1'b0};
            2'd1:    next_byte_s = reg_d;
            2'd2:    next_byte_s = dat_d;
            default: next_byte_s = 8'h00;
        endcase
        next_bit_s          = next_byte_s[bit_d];
        {scl_d, sda_oe_d}   = bus_level(state_d, qtr_d, next_bit_s);
    end

    // State and output registers; reset releases the bus and abandons any transfer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {DIV_W{1'b0}};
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            byte_q    <= 2'd0;
            nack_q    <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            dat_q     <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
`ifdef I2C_WRITE_SEQ_RETRY_EN
            retried_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            nack_q    <= nack_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
`ifdef I2C_WRITE_SEQ_RETRY_EN
            retried_q <= retried_d;
`endif
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.ack_err_o = ack_err_q;
    assign bus.scl_o     = scl_q;
    assign bus.sda_oe_o  = sda_oe_q;

endmodule

// File: tb/tb_i2c_write_seq_ctrl.sv
// Bench for i2c_write_seq_ctrl: stimulus pushes expected transactions into a
// scoreboard queue; an independent bus monitor with an I2C slave model decodes
// SCL/SDA and checks each transaction when done_o is presented.
module tb_i2c_write_seq_ctrl;
    localparam int CLK_DIV = 4;
`ifdef I2C_WRITE_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct packed {
        logic [5:0][7:0] bytes;
        logic [3:0]      nbytes;
        logic [1:0]      nstarts;
        logic            err;
        logic [9:0]      ticks;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_pull;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    exp_t exp_q[$];
    logic slave_plan[$];
    logic [7:0] obs_q[$];

    always #5 clk = ~clk;

    i2c_write_seq_ctrl_if bus();
    assign bus.sda_i = ~(bus.sda_oe_o | slave_pull);

    i2c_write_seq_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bytes on the wire, STARTs, error and tick count from the ACK plan.
    task automatic model(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] d,
                         input logic [5:0] resp);
        exp_t e;
        int   slot;
        logic [7:0] b [0:2];
        logic r;
        e = '0;
        slot = 0;
        b[0] = {dev, 1'b0};
        b[1] = ra;
        b[2] = d;
        for (int att = 0; att < (RETRY ? 2 : 1); att++) begin
            e.nstarts = e.nstarts + 2'd1;
            e.ticks   = e.ticks + 10'd8;
            e.err     = 1'b0;
            for (int k = 0; k < 3; k++) begin
                e.bytes[e.nbytes] = b[k];
                e.nbytes = e.nbytes + 4'd1;
                e.ticks  = e.ticks + 10'd36;
                r = resp[slot];
                slot++;
                slave_plan.push_back(r);
                if (r) begin
                    e.err = 1'b1;
                    break;
                end
            end
            if (!e.err) break;
        end
        exp_q.push_back(e);
    endtask

    task automatic scramble();
        bus.dev_addr_i = 7'($urandom);
        bus.reg_addr_i = 8'($urandom);
        bus.data_i     = 8'($urandom);
    endtask

    task automatic run_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] d,
                           input logic [5:0] resp, input bit hold);
        int n;
        n = 0;
        while (bus.busy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        model(dev, ra, d, resp);
        bus.req_i      = 1'b1;
        bus.dev_addr_i = dev;
        bus.reg_addr_i = ra;
        bus.data_i     = d;
        @(negedge clk);
        if (!hold) begin
            bus.req_i = 1'b0;
            scramble();
        end else begin
            scramble();
        end
        n = 0;
        while (!bus.done_o && n < 2000) begin
            @(negedge clk);
            n++;
            if (hold) scramble();
        end
        check("done_seen", int'(bus.done_o), 1);
        bus.req_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Cycle counter used for done_o latency.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Bus monitor, slave responder and scoreboard checker.
    initial begin
        logic prev_scl, prev_line, prev_busy, cur_scl, cur_line, r;
        int   bitcnt, starts, stops, t_acc;
        logic [7:0] shift;
        exp_t e;
        prev_scl = 1'b1; prev_line = 1'b1; prev_busy = 1'b0;
        bitcnt = 0; starts = 0; stops = 0; t_acc = 0; shift = 8'h00;
        slave_pull = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitcnt = 0; starts = 0; stops = 0; shift = 8'h00;
                obs_q.delete();
                slave_pull = 1'b0;
                prev_scl = 1'b1; prev_line = 1'b1; prev_busy = 1'b0;
            end else begin
                cur_scl  = bus.scl_o;
                cur_line = bus.sda_i;
                if (prev_scl && cur_scl && prev_line && !cur_line) begin
                    check("start_position", bitcnt, 0);
                    starts++;
                    bitcnt = 0;
                end else if (prev_scl && cur_scl && !prev_line && cur_line) begin
                    check("stop_position", bitcnt, 1);
                    stops++;
                    bitcnt = 0;
                end else if (!prev_scl && cur_scl) begin
                    bitcnt++;
                    if (bitcnt <= 8) shift = {shift[6:0], cur_line};
                    if (bitcnt == 8) obs_q.push_back(shift);
                end else if (prev_scl && !cur_scl) begin
                    if (bitcnt == 8) begin
                        r = (slave_plan.size() > 0) ? slave_plan.pop_front() : 1'b0;
                        slave_pull = ~r;
                    end else if (bitcnt == 9) begin
                        slave_pull = 1'b0;
                        bitcnt = 0;
                    end
                end
                if (!prev_busy && bus.busy_o) t_acc = cyc;
                if (bus.done_o) begin
                    if (exp_q.size() == 0) begin
                        check("done_without_request", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_err", int'(bus.ack_err_o), int'(e.err));
                        check("busy_at_done", int'(bus.busy_o), 0);
                        check("byte_count", obs_q.size(), int'(e.nbytes));
                        for (int i = 0; i < obs_q.size() && i < 6; i++)
                            check($sformatf("byte%0d", i), int'(obs_q[i]), int'(e.bytes[i]));
                        check("start_count", starts, int'(e.nstarts));
                        check("stop_count", stops, int'(e.nstarts));
                        check("latency", cyc - t_acc, int'(e.ticks) * CLK_DIV);
                    end
                    obs_q.delete();
                    starts = 0;
                    stops = 0;
                end
                prev_scl  = cur_scl;
                prev_line = cur_line;
                prev_busy = bus.busy_o;
            end
        end
    end

    // Global time bound.
    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic [5:0] resp;
        bus.req_i = 1'b0;
        bus.dev_addr_i = 7'd0;
        bus.reg_addr_i = 8'd0;
        bus.data_i = 8'd0;
        #12;
        check("rst_scl", int'(bus.scl_o), 1);
        check("rst_sda_oe", int'(bus.sda_oe_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_ack_err", int'(bus.ack_err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal write, all ACKed.
        run_txn(7'h39, 8'h41, 8'h10, 6'b000000, 1'b0);
        // Address NACKed (twice, so a retry build also fails).
        run_txn(7'h55, 8'hA0, 8'h5A, 6'b000011, 1'b0);
        // Second ACK NACKed on first attempt only.
        run_txn(7'h12, 8'h34, 8'h56, 6'b000010, 1'b0);
        // Request held high with changing fields while busy.
        run_txn(7'h7F, 8'h00, 8'hFF, 6'b000000, 1'b1);
        run_txn(7'h01, 8'hC3, 8'h3C, 6'b000000, 1'b0);

        // Reset during byte 1.
        @(negedge clk);
        model(7'h2A, 8'h99, 8'h66, 6'b000000);
        bus.req_i = 1'b1;
        bus.dev_addr_i = 7'h2A; bus.reg_addr_i = 8'h99; bus.data_i = 8'h66;
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (200) @(negedge clk);
        check("busy_before_reset", int'(bus.busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_scl", int'(bus.scl_o), 1);
        check("midrst_sda_oe", int'(bus.sda_oe_o), 0);
        check("midrst_busy", int'(bus.busy_o), 0);
        check("midrst_done", int'(bus.done_o), 0);
        exp_q.delete();
        slave_plan.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_txn(7'h2A, 8'h99, 8'h66, 6'b000000, 1'b0);

        // Randomized transactions with varied ACK plans.
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 4))
                0:       resp = 6'b000000;
                1:       resp = 6'b000001;
                2:       resp = 6'b000010;
                3:       resp = 6'b000100;
                default: resp = 6'($urandom);
            endcase
            run_txn(7'($urandom), 8'($urandom), 8'($urandom), resp, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_write_seq_ctrl.md
I2C_WRITE_SEQ_CTRL -- requirements
Module: i2c_write_seq_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 62, meaning clk_i cycles per quarter SCL bit period (100 MHz / (4 x 400 kHz)).
REQ-002 Parameter DIV_W, default 8, meaning width of the quarter-period counter; CLK_DIV-1 SHALL fit in DIV_W bits.
REQ-003 clk_i  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  request one register write; sampled only when busy_o=0.
REQ-006 dev_addr_i  input  7  7-bit I2C slave address.
REQ-007 reg_addr_i  input  8  target register address.
REQ-008 data_i  input  8  register write data.
REQ-009 busy_o  output  1  high from the cycle after acceptance until done_o.
REQ-010 done_o  output  1  one-cycle pulse at transaction end.
REQ-011 ack_err_o  output  1  last transaction ended on NACK.
REQ-012 scl_o  output  1  SCL level (1 = released).
REQ-013 sda_oe_o  output  1  1 = pull SDA low, 0 = release.
REQ-014 sda_i  input  1  sampled SDA line.

Function
REQ-015 Accept: req_i=1 while busy_o=0 SHALL latch dev_addr_i, reg_addr_i, data_i, set busy_o next cycle, clear ack_err_o.
REQ-016 req_i while busy_o=1 SHALL be ignored; no queuing.
REQ-017 Quarter tick: counter counts 0..CLK_DIV-1 while busy, tick on terminal count, held at 0 in IDLE.
REQ-018 States IDLE -> START -> BYTE -> ACK -> (BYTE | STOP) -> DONE -> IDLE; every non-IDLE/DONE transition on a tick only.
REQ-019 START, 4 ticks: q0 SDA released/SCL high; q1 SDA low/SCL high; q2-q3 SDA low/SCL low.
REQ-020 BYTE, 8 bits MSB first, 4 ticks each: q0 SCL low, SDA updated; q1-q2 SCL high; q3 SCL low; SDA SHALL NOT change while SCL high.
REQ-021 Byte order: {dev_addr,1'b0}, reg_addr, data; byte index 0..2.
REQ-022 ACK, 4 ticks: SDA released; sda_i sampled at end of q2; 0 = ACK, 1 = NACK.
REQ-023 ACK after byte 2 or any NACK SHALL go to STOP; ACK after byte 0/1 SHALL go to next BYTE.
REQ-024 STOP, 4 ticks: q0 SDA low/SCL low; q1 SDA low/SCL high; q2-q3 SDA released/SCL high.
REQ-025 DONE: one cycle, done_o=1, busy_o cleared same cycle, ack_err_o=1 on terminal NACK.
REQ-026 Fault-free transaction length SHALL be exactly 116 ticks (4 + 3x36 + 4) plus acceptance and DONE cycles.
REQ-027 A NACK SHALL skip remaining bytes; no data byte after a NACKed address.
REQ-028 Bus idle outside transactions: scl_o=1, sda_oe_o=0.

Reset
REQ-029 rst_n_i=0 SHALL immediately force IDLE, counter 0, scl_o=1, sda_oe_o=0, busy_o=0, done_o=0, ack_err_o=0.
REQ-030 Reset mid-transaction SHALL abandon it without STOP and without done_o; first request after release SHALL begin at START.

Configuration
REQ-031 Macro I2C_WRITE_SEQ_RETRY_EN defined: terminal NACK SHALL pass STOP then restart the whole transaction from START once with latched data; ack_err_o and done_o only after retry ends.
REQ-032 Macro undefined: NACK SHALL go directly via STOP to DONE with ack_err_o=1; no retry logic synthesised.

Verification
REQ-033 CLK_DIV=4, req dev=0x39 reg=0x41 data=0x10, slave ACKs all -> SDA bytes 0x72,0x41,0x10; done_o at 116x4+2 cycles; ack_err_o=0.
REQ-034 Slave NACKs address byte -> no further bytes, STOP, done_o, ack_err_o=1 (retry off); with retry on, two STARTs, then ack_err_o=1.
REQ-035 Slave NACKs second ACK only on first attempt, retry on -> second attempt completes, ack_err_o=0, one done_o.
REQ-036 req_i held high during busy with changed data -> ignored; only first transaction on bus; next accepted after done_o.
REQ-037 rst_n_i low during byte 1 -> scl_o=1, sda_oe_o=0, busy_o=0 immediately; no done_o; new req runs complete transaction.
REQ-038 Protocol checker throughout: SDA never changes while SCL high except at START/STOP.
